// File: rtl/axi_llc_ax_split_ctrl.sv
// axi_llc_ax_split_ctrl: holds one AW/AR burst for a burst cutter and issues its descriptors one per handshake.
// The package supplies default channel/descriptor types; integrations override chan_t/desc_t.
package axi_llc_ax_split_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ax_chan_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic        x_last;
    } ax_desc_t;
endpackage

module axi_llc_ax_split_ctrl #(
    parameter type chan_t   = axi_llc_ax_split_pkg::ax_chan_t,
    parameter type desc_t   = axi_llc_ax_split_pkg::ax_desc_t,
    parameter int  CntWidth = 9
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  chan_t               ax_chan_i,
    input  logic                ax_valid_i,
    output logic                ax_ready_o,
    output chan_t               cut_chan_o,
    input  chan_t               cut_next_chan_i,
    input  desc_t               cut_desc_i,
    output desc_t               desc_o,
    output logic                desc_valid_o,
    input  logic                desc_ready_i,
    output logic                busy_o,
    output logic [CntWidth-1:0] split_cnt_o
);
    typedef enum logic {IDLE, SPLIT} state_e;

    state_e              state_q, state_d;
    chan_t               chan_q, chan_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;

    assign ax_ready_o   = (state_q == IDLE);
    assign desc_valid_o = (state_q == SPLIT);
    assign busy_o       = (state_q == SPLIT);
    assign desc_o       = cut_desc_i;
    assign cut_chan_o   = chan_q;
    assign split_cnt_o  = cnt_q;

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (ax_valid_i) begin
                chan_d  = ax_chan_i;
                cnt_d   = '0;
                state_d = SPLIT;
            end
        end else if (desc_ready_i) begin
            // counter saturates so a miswired cutter cannot make it wrap to zero
            cnt_d = &cnt_q ? cnt_q : cnt_q + CntWidth'(1);
            if (cut_desc_i.x_last) state_d = IDLE;
            else chan_d = cut_next_chan_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            chan_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            cnt_q   <= cnt_d;
        end
    end

    a_desc_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        desc_valid_o && !desc_ready_i |=> $stable(desc_o));
    a_ready_valid_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(ax_ready_o && desc_valid_o));
endmodule
